dmem_port_buffer: RTL and testbench
===================================

Name: dmem_port_buffer

Overview:
- Parametrised data-memory port stage between the CPU core's dmem request/response pins and the external memory in the synthesis top.
- Decouples core timing from memory `ready` through a registered request FIFO.
- Bounds in-flight loads with an outstanding-read counter and registers the response path.
- Provides idle and error status for physical-design timing closure and bring-up.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, write/read data width.
- REQ_DEPTH, 2, request FIFO entries (>=2, power of two).
- MAX_OUTSTANDING, 4, maximum issued reads awaiting response (>=1).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- core_req_valid  in  1  core request valid.
- core_req_ready  out  1  buffer can accept a request.
- core_req_we  in  1  1=store, 0=load.
- core_req_addr  in  ADDR_W  request address.
- core_req_data  in  DATA_W  store data.
- core_resp_valid  out  1  load response to core (core cannot backpressure).
- core_resp_data  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  head entry we.
- mem_req_addr  out  ADDR_W  head entry address.
- mem_req_data  out  DATA_W  head entry data.
- mem_resp_valid  in  1  memory load response.
- mem_resp_data  in  DATA_W  load data.
- outstanding  out  clog2(MAX_OUTSTANDING+1)  issued reads not yet answered.
- idle  out  1  FIFO empty and outstanding==0.
- err_spurious_resp  out  1  sticky: response arrived with outstanding==0.

Behaviour:
- Reset: FIFO empty, pointers 0, outstanding=0, core_resp_valid=0, core_resp_data=0, err_spurious_resp=0. Hence core_req_ready=1, mem_req_valid=0, idle=1. Reset mid-operation discards queued requests and in-flight accounting. Responses arriving in the reset cycle are dropped.
- Enqueue:
  - core_req_ready = !full; push on core_req_valid && core_req_ready.
  - No same-cycle push-through when full, even if a pop occurs that cycle. core_req_ready depends only on registered state.
- Issue:
  - mem_req_* driven directly from the FIFO head register. Minimum latency push->mem_req_valid = 1 cycle.
  - mem_req_valid = !empty && (head_we || outstanding < MAX_OUTSTANDING).
  - A load at the head with the counter saturated blocks younger stores; issue is in order.
  - Pop on mem_req_valid && mem_req_ready. Push and pop in the same cycle when neither full nor empty: count unchanged.
  - mem_req_* stay stable while mem_req_valid=1 && !mem_req_ready.
- Outstanding counter:
  - +1 on load issue; -1 on mem_resp_valid while outstanding>0; both in the same cycle: unchanged.
  - Stores never counted and produce no response.
- Response:
  - core_resp_valid <= mem_resp_valid && (outstanding>0); core_resp_data <= mem_resp_data when accepted, else holds.
  - Latency 1 cycle, one response per cycle, order preserved (memory returns in order).
- Spurious response: mem_resp_valid with outstanding==0. It is not forwarded, the counter is unchanged, and err_spurious_resp is set until reset.
- Pointers wrap modulo REQ_DEPTH; full/empty are tracked with an extra pointer bit.
- idle is combinational from registered state.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> core_req_ready=1, mem_req_valid=0, outstanding=0, idle=1, err_spurious_resp=0.
- Single load: push load addr=0x100 at cycle 0, mem_req_ready=1 -> mem_req_valid=1 with addr 0x100 at cycle 1, outstanding=1 at cycle 2. Then mem_resp_valid=1, data=0xDEADBEEF at cycle 4 -> core_resp_valid=1, data=0xDEADBEEF at cycle 5; outstanding=0, idle=1.
- Backpressure/full: mem_req_ready=0; push stores 0x0, 0x4, 0x8 back-to-back -> first two accepted, core_req_ready=0 afterwards, mem_req_addr held at 0x0. Release ready -> addresses 0x0, 0x4 issued in order on consecutive cycles.
- Outstanding limit: MAX_OUTSTANDING=4; issue 5 loads with no responses -> 4 issued, 5th held (mem_req_valid=0), and a store queued behind it also held. One response -> 5th load issues next cycle, outstanding stays 4.
- Simultaneous events: load issue and mem_resp_valid in the same cycle at outstanding=2 -> outstanding stays 2 and the response is forwarded next cycle.
- Spurious response and reset mid-op: mem_resp_valid with outstanding=0 -> core_resp_valid stays 0, err_spurious_resp=1 persists. Reset with 2 queued and 3 outstanding -> all cleared, idle=1 next cycle.

Source files
------------

// File: rtl/dmem_port_buffer.sv
// Data-memory port stage: registered request FIFO toward memory, bounded
// in-flight load accounting, and a registered load-response path to the core.
module dmem_port_buffer #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int REQ_DEPTH       = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     core_req_valid,
   output logic                                     core_req_ready,
   input  logic                                     core_req_we,
   input  logic [ADDR_W-1:0]                        core_req_addr,
   input  logic [DATA_W-1:0]                        core_req_data,
   output logic                                     core_resp_valid,
   output logic [DATA_W-1:0]                        core_resp_data,
   output logic                                     mem_req_valid,
   input  logic                                     mem_req_ready,
   output logic                                     mem_req_we,
   output logic [ADDR_W-1:0]                        mem_req_addr,
   output logic [DATA_W-1:0]                        mem_req_data,
   input  logic                                     mem_resp_valid,
   input  logic [DATA_W-1:0]                        mem_resp_data,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
   output logic                                     idle,
   output logic                                     err_spurious_resp
);

   localparam int PTR_W = $clog2(REQ_DEPTH);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   logic              fifo_we   [REQ_DEPTH];
   logic [ADDR_W-1:0] fifo_addr [REQ_DEPTH];
   logic [DATA_W-1:0] fifo_data [REQ_DEPTH];

   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           load_issue;
   logic           resp_ok;
   logic           at_limit;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
              (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   end

   always_comb begin
      mem_req_we   = fifo_we[rd_ptr[PTR_W-1:0]];
      mem_req_addr = fifo_addr[rd_ptr[PTR_W-1:0]];
      mem_req_data = fifo_data[rd_ptr[PTR_W-1:0]];
      at_limit     = (outstanding == MAX_CNT);
      // A saturated load at the head also stalls younger stores: issue stays in order.
      mem_req_valid  = !empty && (mem_req_we || !at_limit);
      core_req_ready = !full;
      push           = core_req_valid && core_req_ready;
      pop            = mem_req_valid && mem_req_ready;
      load_issue     = pop && !mem_req_we;
      resp_ok        = mem_resp_valid && (outstanding != '0);
      idle           = empty && (outstanding == '0);
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_we[wr_ptr[PTR_W-1:0]]   <= core_req_we;
         fifo_addr[wr_ptr[PTR_W-1:0]] <= core_req_addr;
         fifo_data[wr_ptr[PTR_W-1:0]] <= core_req_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         outstanding       <= '0;
         core_resp_valid   <= 1'b0;
         core_resp_data    <= '0;
         err_spurious_resp <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({load_issue, resp_ok})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase

         core_resp_valid <= resp_ok;
         if (resp_ok) core_resp_data <= mem_resp_data;

         if (mem_resp_valid && (outstanding == '0)) err_spurious_resp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_port_buffer.sv
// Scoreboard bench for dmem_port_buffer: expected memory requests and core
// responses are queued by the stimulus and checked by an independent monitor.
module tb_dmem_port_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        core_req_valid, core_req_ready, core_req_we;
   logic [31:0] core_req_addr, core_req_data;
   logic        core_resp_valid;
   logic [31:0] core_resp_data;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_data;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic [2:0]  outstanding;
   logic        idle, err_spurious_resp;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   req_t        exp_req [$];
   logic [31:0] exp_resp [$];
   req_t        mon_req;
   logic [31:0] mon_resp;

   int compared   = 0;
   int mismatched = 0;
   bit run        = 1'b0;

   dmem_port_buffer #(
      .ADDR_W(32), .DATA_W(32), .REQ_DEPTH(2), .MAX_OUTSTANDING(4)
   ) dut (
      .clock(clock), .reset(reset),
      .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
      .core_req_we(core_req_we), .core_req_addr(core_req_addr),
      .core_req_data(core_req_data),
      .core_resp_valid(core_resp_valid), .core_resp_data(core_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .outstanding(outstanding), .idle(idle),
      .err_spurious_resp(err_spurious_resp)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a transfer.
   always @(negedge clock) begin
      if (run && !reset) begin
         if (mem_req_valid && mem_req_ready) begin
            if (exp_req.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL unexpected_mem_req: got addr 0x%0h we %0d, expected none",
                        mem_req_addr, mem_req_we);
            end else begin
               mon_req = exp_req.pop_front();
               check("mem_req_we",   {63'd0, mem_req_we}, {63'd0, mon_req.we});
               check("mem_req_addr", {32'd0, mem_req_addr}, {32'd0, mon_req.addr});
               check("mem_req_data", {32'd0, mem_req_data}, {32'd0, mon_req.data});
            end
         end
         if (core_resp_valid) begin
            if (exp_resp.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL unexpected_core_resp: got data 0x%0h, expected none", core_resp_data);
            end else begin
               mon_resp = exp_resp.pop_front();
               check("core_resp_data", {32'd0, core_resp_data}, {32'd0, mon_resp});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input bit track);
      int n = 0;
      while (!core_req_ready && n < 20) begin
         tick();
         n++;
      end
      if (!core_req_ready) begin
         compared++; mismatched++;
         $display("FAIL push_timeout: got core_req_ready 0, expected 1 within 20 cycles");
      end else begin
         core_req_valid = 1'b1;
         core_req_we    = we;
         core_req_addr  = addr;
         core_req_data  = data;
         if (track) exp_req.push_back('{we: we, addr: addr, data: data});
         tick();
         core_req_valid = 1'b0;
      end
   endtask

   task automatic resp(input logic [31:0] d, input bit track);
      mem_resp_valid = 1'b1;
      mem_resp_data  = d;
      if (track) exp_resp.push_back(d);
      tick();
      mem_resp_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      core_req_valid = 1'b0; core_req_we = 1'b0;
      core_req_addr = '0; core_req_data = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

      // Reset then idle
      tick(); tick();
      reset = 1'b0;
      run = 1'b1;
      check("rst_core_req_ready", core_req_ready, 1);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_idle", idle, 1);
      check("rst_err", err_spurious_resp, 0);
      check("rst_core_resp_valid", core_resp_valid, 0);

      // Single load
      mem_req_ready = 1'b1;
      push(1'b0, 32'h100, 32'h0, 1'b1);
      check("load_mem_req_valid", mem_req_valid, 1);
      check("load_mem_req_addr", mem_req_addr, 32'h100);
      tick();
      check("load_outstanding", outstanding, 1);
      check("load_idle_busy", idle, 0);
      tick();
      resp(32'hDEADBEEF, 1'b1);
      check("load_resp_valid", core_resp_valid, 1);
      check("load_resp_data", core_resp_data, 32'hDEADBEEF);
      check("load_outstanding_zero", outstanding, 0);
      check("load_idle", idle, 1);
      tick();

      // Backpressure / full
      mem_req_ready = 1'b0;
      push(1'b1, 32'h0, 32'h11, 1'b1);
      push(1'b1, 32'h4, 32'h22, 1'b1);
      check("full_ready", core_req_ready, 0);
      core_req_valid = 1'b1; core_req_we = 1'b1;
      core_req_addr = 32'h8; core_req_data = 32'h33;
      tick();
      core_req_valid = 1'b0;
      check("full_ready_held", core_req_ready, 0);
      check("full_head_addr", mem_req_addr, 32'h0);
      check("full_head_valid", mem_req_valid, 1);
      mem_req_ready = 1'b1;
      tick();
      check("drain_second_addr", mem_req_addr, 32'h4);
      check("drain_second_valid", mem_req_valid, 1);
      tick();
      check("drain_idle", idle, 1);

      // Outstanding limit: four loads issue, fifth and the store behind it stall
      for (int i = 0; i < 5; i++) push(1'b0, 32'h200 + 32'(4 * i), 32'h0, 1'b1);
      push(1'b1, 32'h300, 32'h55, 1'b1);
      check("limit_outstanding", outstanding, 4);
      check("limit_mem_req_valid", mem_req_valid, 0);
      check("limit_full", core_req_ready, 0);
      tick();
      check("limit_store_blocked", mem_req_valid, 0);
      resp(32'hA0, 1'b1);
      check("limit_after_resp_cnt", outstanding, 3);
      check("limit_after_resp_valid", mem_req_valid, 1);
      tick();
      check("limit_refill_cnt", outstanding, 4);
      check("limit_store_issues", mem_req_valid, 1);
      tick();
      check("limit_store_not_counted", outstanding, 4);
      check("limit_empty", mem_req_valid, 0);

      // Simultaneous load issue and response at outstanding=2
      resp(32'hA1, 1'b1);
      resp(32'hA2, 1'b1);
      push(1'b0, 32'h400, 32'h0, 1'b1);
      check("simul_pre_cnt", outstanding, 2);
      check("simul_pre_valid", mem_req_valid, 1);
      mem_resp_valid = 1'b1; mem_resp_data = 32'hA3;
      exp_resp.push_back(32'hA3);
      tick();
      mem_resp_valid = 1'b0;
      check("simul_cnt", outstanding, 2);
      check("simul_resp_valid", core_resp_valid, 1);
      resp(32'hA4, 1'b1);
      resp(32'hA5, 1'b1);
      check("simul_drained_idle", idle, 1);

      // Spurious response
      resp(32'hBAD, 1'b0);
      check("spur_resp_valid", core_resp_valid, 0);
      check("spur_err", err_spurious_resp, 1);
      check("spur_cnt", outstanding, 0);
      tick(); tick();
      check("spur_err_sticky", err_spurious_resp, 1);

      // Reset with 2 queued and 3 outstanding
      push(1'b0, 32'h500, 32'h0, 1'b1);
      push(1'b0, 32'h504, 32'h0, 1'b1);
      push(1'b0, 32'h508, 32'h0, 1'b1);
      tick();
      mem_req_ready = 1'b0;
      push(1'b1, 32'h600, 32'h66, 1'b0);
      push(1'b1, 32'h604, 32'h67, 1'b0);
      check("midop_cnt", outstanding, 3);
      check("midop_full", core_req_ready, 0);
      reset = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'hCC;
      tick();
      reset = 1'b0;
      mem_resp_valid = 1'b0;
      check("midop_idle", idle, 1);
      check("midop_cnt_clr", outstanding, 0);
      check("midop_mem_req_valid", mem_req_valid, 0);
      check("midop_ready", core_req_ready, 1);
      check("midop_err_clr", err_spurious_resp, 0);
      check("midop_resp_dropped", core_resp_valid, 0);

      // Normal operation after reset
      mem_req_ready = 1'b1;
      push(1'b1, 32'h700, 32'h77, 1'b1);
      tick(); tick();
      check("post_idle", idle, 1);
      check("pending_mem_reqs", exp_req.size(), 0);
      check("pending_core_resps", exp_resp.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
